// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: FSM state encoding,
// AES-128 round count and round-constant arithmetic.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [7:0] RCON_LAST = 8'h36;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], 1'b0};
    return b[7] ? (s ^ RCON_POLY) : s;
  endfunction

  // Divide by x in GF(2^8): the exact inverse of xtime.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [7:0] t;
    t = b ^ RCON_POLY;
    return b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads the first constant of a block and steps
// forward (xtime) or backward (inverse xtime) once per key-schedule step.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic       reverse,
  output logic [7:0] rcon
);

  // Load has priority over step so a new block always restarts the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcon <= RCON_INIT;
    end else if (load) begin
      rcon <= reverse ? RCON_LAST : RCON_INIT;
    end else if (step) begin
      rcon <= reverse ? inv_xtime(rcon) : xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath and key schedule.
// Optional decryption ordering is enabled with AES_ROUND_CTRL_DECRYPT_EN.
// All outputs are registered: each is computed from the next-state values
// so that it is valid during the cycle the state describes.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int ROUND_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  input  logic       decrypt,
`endif
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       load_state,
  output logic       round_en,
  output logic       skip_mc,
  output logic       skip_sub,
  output logic       key_step,
  output logic [7:0] rcon,
  output logic [3:0] round_idx,
  output logic       busy
);

  localparam int            CW       = $clog2(ROUND_LAT) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_LAT - 1);
  localparam logic [3:0]    R_LAST   = 4'(NR);

  state_t        state, nxt_state;
  logic [3:0]    nxt_round;
  logic [CW-1:0] cyc_cnt, nxt_cyc;
  logic          accept;
  logic          dec, nxt_dec;
  logic          run_n, last_n;

  // First processed round: 0 when encrypting, NR when decrypting.
  function automatic logic is_first(input logic [3:0] r, input logic d);
    return d ? (r == R_LAST) : (r == 4'd0);
  endfunction

  // Final round (no MixColumns, no key step).
  function automatic logic is_final(input logic [3:0] r, input logic d);
    return d ? (r == 4'd0) : (r == R_LAST);
  endfunction

`ifdef AES_ROUND_CTRL_DECRYPT_EN
  // Direction is captured with the block and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec <= 1'b0;
    end else if (accept) begin
      dec <= decrypt;
    end
  end
  assign nxt_dec = accept ? decrypt : dec;
`else
  assign dec     = 1'b0;
  assign nxt_dec = 1'b0;
`endif

  // Next-state logic: round/cycle counters advance only while running.
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    nxt_state = state;
    nxt_round = round_idx;
    nxt_cyc   = cyc_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nxt_state = RUN;
          nxt_round = nxt_dec ? R_LAST : 4'd0;
          nxt_cyc   = '0;
        end
      end
      RUN: begin
        if (cyc_cnt == CYC_LAST) begin
          nxt_cyc = '0;
          if (is_final(round_idx, dec)) begin
            nxt_state = DONE;
          end else begin
            nxt_round = dec ? (round_idx - 4'd1) : (round_idx + 4'd1);
          end
        end else begin
          nxt_cyc = cyc_cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
    run_n  = (nxt_state == RUN);
    last_n = (nxt_cyc == CYC_LAST);
  end

  // State and registered strobes; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      round_idx  <= 4'd0;
      cyc_cnt    <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      load_state <= 1'b0;
      round_en   <= 1'b0;
      skip_mc    <= 1'b0;
      skip_sub   <= 1'b0;
      key_step   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      round_idx  <= nxt_round;
      cyc_cnt    <= nxt_cyc;
      in_ready   <= (nxt_state == IDLE);
      out_valid  <= (nxt_state == DONE);
      busy       <= (nxt_state != IDLE);
      load_state <= accept;
      round_en   <= run_n && last_n;
      key_step   <= run_n && last_n && !is_final(nxt_round, nxt_dec);
      skip_sub   <= run_n && is_first(nxt_round, nxt_dec);
      skip_mc    <= run_n && (is_first(nxt_round, nxt_dec) || is_final(nxt_round, nxt_dec));
    end
  end

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (key_step),
    .reverse (nxt_dec),
    .rcon    (rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: two instances (ROUND_LAT 1 and 3)
// share stimulus; a cycle-offset reference model checks both every cycle.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       load_state;
    logic       round_en;
    logic       skip_mc;
    logic       skip_sub;
    logic       key_step;
    logic       busy;
    logic [3:0] round_idx;
    logic [7:0] rcon;
  } obs_t;

  typedef struct {
    logic iv;
    logic ordy;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready, decrypt;

  logic       a_in_ready, a_out_valid, a_load_state, a_round_en, a_skip_mc;
  logic       a_skip_sub, a_key_step, a_busy;
  logic [7:0] a_rcon;
  logic [3:0] a_round_idx;
  logic       b_in_ready, b_out_valid, b_load_state, b_round_en, b_skip_mc;
  logic       b_skip_sub, b_key_step, b_busy;
  logic [7:0] b_rcon;
  logic [3:0] b_round_idx;

  aes_round_ctrl #(.NR(NR), .ROUND_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .load_state(a_load_state), .round_en(a_round_en), .skip_mc(a_skip_mc),
    .skip_sub(a_skip_sub), .key_step(a_key_step), .rcon(a_rcon),
    .round_idx(a_round_idx), .busy(a_busy)
  );

  aes_round_ctrl #(.NR(NR), .ROUND_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .load_state(b_load_state), .round_en(b_round_en), .skip_mc(b_skip_mc),
    .skip_sub(b_skip_sub), .key_step(b_key_step), .rcon(b_rcon),
    .round_idx(b_round_idx), .busy(b_busy)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {a_in_ready, a_out_valid, a_load_state, a_round_en, a_skip_mc,
                  a_skip_sub, a_key_step, a_busy, a_round_idx, a_rcon};
  assign obs_b = {b_in_ready, b_out_valid, b_load_state, b_round_en, b_skip_mc,
                  b_skip_sub, b_key_step, b_busy, b_round_idx, b_rcon};

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rtab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  // Reference model: per instance, whether a block is held and how many
  // cycles have elapsed since it was accepted (1 = cycle after accept).
  int lat   [2] = '{1, 3};
  bit m_busy[2] = '{1'b0, 1'b0};
  int m_k   [2] = '{0, 0};
  bit m_dec [2] = '{1'b0, 1'b0};

  function automatic obs_t mk(input logic ir, ov, ld, ren, smc, ssub, ks, bz,
                              input logic [3:0] ri, input logic [7:0] rc);
    obs_t o;
    o = {ir, ov, ld, ren, smc, ssub, ks, bz, ri, rc};
    return o;
  endfunction

  function automatic obs_t model_exp(input int i);
    obs_t e;
    int run_len, pos, c;
    e = '0;
    run_len = (NR + 1) * lat[i];
    if (!m_busy[i]) begin
      e.in_ready = 1'b1;
    end else begin
      e.busy = 1'b1;
      if (m_k[i] <= run_len) begin
        pos = (m_k[i] - 1) / lat[i];
        c   = (m_k[i] - 1) % lat[i];
        e.load_state = (m_k[i] == 1);
        e.round_en   = (c == lat[i] - 1);
        e.key_step   = e.round_en && (pos < NR);
        e.skip_sub   = (pos == 0);
        e.skip_mc    = (pos == 0) || (pos == NR);
        e.round_idx  = m_dec[i] ? 4'(NR - pos) : 4'(pos);
        if (e.key_step) e.rcon = m_dec[i] ? rtab[NR - 1 - pos] : rtab[pos];
      end else begin
        e.out_valid = 1'b1;
        e.round_idx = m_dec[i] ? 4'd0 : 4'(NR);
      end
    end
    return e;
  endfunction

  function automatic obs_t msk(input obs_t a, input obs_t e);
    obs_t m;
    m = a;
    if (!e.busy) m.round_idx = '0;
    if (!e.key_step) m.rcon = '0;
    return m;
  endfunction

  task automatic cmp_obs(input string nm, input obs_t a, input obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, a, e);
    end
  endtask

  task automatic cmp_int(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, a, e);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (in_valid) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 1;
          m_dec[i]  = decrypt;
        end
      end else if (m_k[i] > (NR + 1) * lat[i] && out_ready) begin
        m_busy[i] = 1'b0;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  task automatic tick();
    obs_t ea, eb;
    @(posedge clk);
    model_edge();
    #1;
    ea = model_exp(0);
    eb = model_exp(1);
    cmp_obs("model_lat1", msk(obs_a, ea), ea);
    cmp_obs("model_lat3", msk(obs_b, eb), eb);
  endtask

  task automatic wait_idle();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!(a_in_ready && b_in_ready) && n < 100) begin
      tick();
      n++;
    end
    cmp_int("wait_idle_timeout", int'(n < 100), 1);
  endtask

  vec_t tbl [18];

  initial begin
    int   loads [$];
    logic [7:0] rq [$];
    logic [3:0] iq [$];
    int   n;

    // Directed single block with backpressure, checked on the ROUND_LAT=1 instance.
    tbl[0] = '{1'b1, 1'b0, mk(0,0,1,1,1,1,1,1, 4'd0, 8'h01)};
    for (int r = 1; r <= 9; r++)
      tbl[r] = '{1'b1, 1'b1, mk(0,0,0,1,0,0,1,1, 4'(r), rtab[r])};
    tbl[10] = '{1'b1, 1'b1, mk(0,0,0,1,1,0,0,1, 4'd10, 8'h00)};
    tbl[11] = '{1'b0, 1'b1, mk(0,1,0,0,0,0,0,1, 4'd10, 8'h00)};
    for (int r = 12; r <= 16; r++)
      tbl[r] = '{1'b0, 1'b0, mk(0,1,0,0,0,0,0,1, 4'd10, 8'h00)};
    tbl[17] = '{1'b0, 1'b1, mk(1,0,0,0,0,0,0,0, 4'd0, 8'h00)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
    repeat (3) tick();
    cmp_obs("reset_lat1", obs_a, mk(1,0,0,0,0,0,0,0, 4'd0, 8'h01));
    cmp_obs("reset_lat3", obs_b, mk(1,0,0,0,0,0,0,0, 4'd0, 8'h01));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      tick();
      cmp_obs($sformatf("table_row%0d", i), msk(obs_a, tbl[i].exp), tbl[i].exp);
    end
    wait_idle();

    // ROUND_LAT=3: out_valid 34 cycles after the accepting cycle.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 60) begin
      tick();
      n++;
    end
    cmp_int("lat3_out_valid_cycle", n, 34);
    wait_idle();

    // Reset in the middle of a block, then a clean block.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_obs("midrst_idle", msk(obs_a, mk(1,0,0,0,0,0,0,0, 4'd0, 8'h00)),
            mk(1,0,0,0,0,0,0,0, 4'd0, 8'h00));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 30) begin
      if (a_key_step) rq.push_back(a_rcon);
      tick();
      n++;
    end
    cmp_int("midrst_keysteps", rq.size(), 10);
    for (int i = 0; i < rq.size() && i < 10; i++)
      cmp_int($sformatf("midrst_rcon%0d", i), int'(rq[i]), int'(rtab[i]));
    wait_idle();

    // Back-to-back: in_valid held, consumer always ready.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (a_load_state) loads.push_back(c);
    end
    cmp_int("b2b_accepts", loads.size(), 4);
    for (int i = 1; i < loads.size(); i++)
      cmp_int($sformatf("b2b_spacing%0d", i), loads[i] - loads[i-1], 13);
    wait_idle();

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    // Decrypt ordering: round index counts down, rcon runs backwards.
    rq.delete();
    decrypt  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    decrypt  = 1'b0;
    n = 0;
    while (!a_out_valid && n < 30) begin
      if (a_key_step) rq.push_back(a_rcon);
      if (a_round_en) iq.push_back(a_round_idx);
      tick();
      n++;
    end
    cmp_int("dec_keysteps", rq.size(), 10);
    for (int i = 0; i < rq.size() && i < 10; i++)
      cmp_int($sformatf("dec_rcon%0d", i), int'(rq[i]), int'(rtab[9 - i]));
    cmp_int("dec_rounds", iq.size(), 11);
    for (int i = 0; i < iq.size() && i < 11; i++)
      cmp_int($sformatf("dec_round%0d", i), int'(iq[i]), NR - i);
    wait_idle();
`endif

    // Random traffic with occasional resets, checked against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      rst       = ($urandom_range(0, 299) == 0);
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      decrypt   = ($urandom_range(0, 1) != 0);
`endif
      tick();
    end
    rst = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
